// File: rtl/ring_nic_if.sv
// Processor register port and router PE link of the ring NIC.
// master = processor/router side, slave = the NIC itself.
interface ring_nic_if #(
  parameter int DATA_WIDTH = 64
);
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;

  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  polarity;

  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_ro, polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_ro, polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/ring_nic.sv
// Ring NIC: one-entry output and input channel buffers between a processor
// register port and a ring router PE port, with even/odd VC injection.
module ring_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63
) (
  input  logic       clk,
  input  logic       reset,
  ring_nic_if.slave  nic
);

  logic                  out_full;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] out_buf;
  logic [DATA_WIDTH-1:0] in_buf;

  logic                  wr_out;
  logic                  rd_in;
  logic                  send;
  logic                  recv;
  logic [DATA_WIDTH-1:0] d_out_c;

  // Acceptance looks at out_full before the edge, so a write colliding with
  // an injection is dropped rather than queued.
  assign wr_out = nic.nicEn & nic.nicWrEn & (nic.addr == 2'b10) & ~out_full;
  assign rd_in  = nic.nicEn & ~nic.nicWrEn & (nic.addr == 2'b00);
  assign send   = out_full & nic.net_ro & (out_buf[VC_BIT] == nic.polarity);
  assign recv   = nic.net_si & ~in_full;

  assign nic.net_so = send;
  assign nic.net_do = out_buf;
  assign nic.net_ri = ~in_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_full <= 1'b0;
      out_buf  <= '0;
    end else if (wr_out) begin
      out_buf  <= nic.d_in;
      out_full <= 1'b1;
    end else if (send) begin
      out_full <= 1'b0;
    end
  end

  // recv needs in_full=0, so it never coincides with a clearing read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_full <= 1'b0;
      in_buf  <= '0;
    end else if (recv) begin
      in_buf  <= nic.net_di;
      in_full <= 1'b1;
    end else if (rd_in) begin
      in_full <= 1'b0;
    end
  end

  always_comb begin
    d_out_c = '0;
    if (nic.nicEn) begin
      unique case (nic.addr)
        2'b00: d_out_c = in_buf;
        2'b01: d_out_c = {{(DATA_WIDTH-1){1'b0}}, in_full};
        2'b10: d_out_c = out_buf;
        2'b11: d_out_c = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default: d_out_c = '0;
      endcase
    end
  end

  assign nic.d_out = d_out_c;

endmodule

// File: tb/tb_ring_nic.sv
// Directed and randomized checks of ring_nic against a queue-based model of
// its two one-entry channels.
module tb_ring_nic;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ring_nic_if #(.DATA_WIDTH(64)) bus ();

  ring_nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
    .clk   (clk),
    .reset (reset),
    .nic   (bus.slave)
  );

  // Model: each channel is a queue holding at most one packet; the last
  // value ever stored is kept separately because the buffers are not cleared.
  logic [63:0] out_q[$];
  logic [63:0] in_q[$];
  logic [63:0] m_out_last;
  logic [63:0] m_in_last;

  task automatic model_reset();
    out_q.delete();
    in_q.delete();
    m_out_last = '0;
    m_in_last  = '0;
  endtask

  function automatic logic exp_so();
    return (out_q.size() == 1) && bus.net_ro && (out_q[0][63] == bus.polarity);
  endfunction

  function automatic logic [63:0] exp_dout();
    if (!bus.nicEn) return 64'd0;
    case (bus.addr)
      2'd0:    return m_in_last;
      2'd1:    return 64'(in_q.size());
      2'd2:    return m_out_last;
      default: return 64'(out_q.size());
    endcase
  endfunction

  task automatic model_edge();
    logic snd;
    snd = exp_so();
    if (bus.nicEn && bus.nicWrEn && bus.addr == 2'd2 && out_q.size() == 0) begin
      out_q.push_back(bus.d_in);
      m_out_last = bus.d_in;
    end else if (snd) begin
      void'(out_q.pop_front());
    end
    if (bus.net_si && in_q.size() == 0) begin
      in_q.push_back(bus.net_di);
      m_in_last = bus.net_di;
    end else if (bus.nicEn && !bus.nicWrEn && bus.addr == 2'd0 && in_q.size() != 0) begin
      void'(in_q.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the model, then advance one clock edge.
  task automatic cyc();
    #1;
    chk("net_so", 64'(bus.net_so), 64'(exp_so()));
    chk("net_ri", 64'(bus.net_ri), 64'(in_q.size() == 0));
    chk("net_do", bus.net_do, m_out_last);
    chk("d_out",  bus.d_out, exp_dout());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [63:0] v);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = 2'd2; bus.d_in = v;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
  endtask

  task automatic idle();
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.addr = 2'd0;
  endtask

  localparam logic [63:0] V1 = 64'h8000_0000_0004_00AA;
  localparam logic [63:0] VA = 64'h0000_0000_0000_0A0A;
  localparam logic [63:0] VB = 64'h0000_0000_0000_0B0B;
  localparam logic [63:0] P1 = 64'h0000_0000_0000_1234;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_6666;
  localparam logic [63:0] VD = 64'h8000_0000_0000_0DDD;
  localparam logic [63:0] VC = 64'h0000_0000_0000_0CCC;

  initial begin
    idle();
    bus.d_in = '0; bus.net_ro = 1'b0; bus.polarity = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0;
    model_reset();
    #1;
    chk("rst_so", 64'(bus.net_so), 64'd0);
    chk("rst_ri", 64'(bus.net_ri), 64'd1);
    chk("rst_do", bus.net_do, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset asserted while a packet is being offered to the router.
    wr(V1); bus.net_ro = 1'b1; bus.polarity = 1'b1;
    cyc();
    rd(2'd2);
    #1 chk("pre_rst_so", 64'(bus.net_so), 64'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_so", 64'(bus.net_so), 64'd0);
    chk("mid_rst_ri", 64'(bus.net_ri), 64'd1);
    chk("mid_rst_dout", bus.d_out, 64'd0);
    rd(2'd3); #1 chk("mid_rst_st_out", bus.d_out, 64'd0);
    rd(2'd1); #1 chk("mid_rst_st_in", bus.d_out, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // VC=1 packet waits for the odd cycle.
    wr(V1); bus.net_ro = 1'b1; bus.polarity = 1'b0;
    cyc();
    idle();
    #1 chk("even_so", 64'(bus.net_so), 64'd0);
    cyc();
    bus.polarity = 1'b1;
    #1 chk("odd_so", 64'(bus.net_so), 64'd1);
    chk("odd_do", bus.net_do, V1);
    cyc();
    bus.polarity = 1'b0; rd(2'd3);
    #1 chk("sent_status", bus.d_out, 64'd0);
    cyc();

    // Blocked by net_ro=0; a second write is dropped.
    wr(VA); bus.net_ro = 1'b0;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.polarity = 1'(i);
      #1 chk("blocked_so", 64'(bus.net_so), 64'd0);
      cyc();
    end
    wr(VB);
    cyc();
    rd(2'd2); bus.net_ro = 1'b1; bus.polarity = 1'b0;
    #1 chk("kept_first", bus.d_out, VA);
    chk("release_so", 64'(bus.net_so), 64'd1);
    chk("release_do", bus.net_do, VA);
    cyc();

    // Receive path and clearing read.
    idle(); bus.net_si = 1'b1; bus.net_di = P1;
    #1 chk("rx_ri_before", 64'(bus.net_ri), 64'd1);
    cyc();
    bus.net_si = 1'b0; rd(2'd1);
    #1 chk("rx_ri_full", 64'(bus.net_ri), 64'd0);
    chk("rx_status", bus.d_out, 64'd1);
    cyc();
    rd(2'd0);
    #1 chk("rx_read", bus.d_out, P1);
    cyc();
    idle();
    #1 chk("rx_ri_after", 64'(bus.net_ri), 64'd1);
    cyc();

    // Router holds a second packet while the buffer is full.
    bus.net_si = 1'b1; bus.net_di = P1;
    cyc();
    bus.net_di = P2;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ri", 64'(bus.net_ri), 64'd0);
      cyc();
    end
    rd(2'd0);
    #1 chk("hold_no_overwrite", bus.d_out, P1);
    cyc();
    idle();
    #1 chk("hold_ri_free", 64'(bus.net_ri), 64'd1);
    cyc();
    bus.net_si = 1'b0; rd(2'd0);
    #1 chk("hold_second", bus.d_out, P2);
    cyc();

    // Write on the same edge as an injection is rejected; retry succeeds.
    wr(VD); bus.net_ro = 1'b1; bus.polarity = 1'b0;
    cyc();
    wr(VC); bus.polarity = 1'b1;
    #1 chk("coll_so", 64'(bus.net_so), 64'd1);
    cyc();
    rd(2'd3); bus.polarity = 1'b0;
    #1 chk("coll_status", bus.d_out, 64'd0);
    cyc();
    wr(VC);
    cyc();
    rd(2'd3); bus.net_ro = 1'b0;
    #1 chk("retry_status", bus.d_out, 64'd1);
    cyc();
    rd(2'd2);
    #1 chk("retry_value", bus.d_out, VC);
    cyc();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.nicEn    = 1'($urandom_range(0, 1));
      bus.nicWrEn  = 1'($urandom_range(0, 1));
      bus.addr     = 2'($urandom_range(0, 3));
      bus.d_in     = {$urandom, $urandom};
      bus.net_ro   = ($urandom_range(0, 3) != 0);
      bus.polarity = 1'($urandom_range(0, 1));
      bus.net_si   = 1'($urandom_range(0, 1));
      bus.net_di   = {$urandom, $urandom};
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller connecting one processor to the PE port of a ring router.
- Acts as the other end of the router's PE send/ready link:
  - Transmitter into the router's PE input (pedi/pesi/peri).
  - Receiver from the router's PE output (pedo/peso/pero).
- Holds one-entry output and input channel buffers, each with a status flag. The processor reaches them through a 2-bit addressed register port.
- Honours the router's even/odd polarity so a packet is injected only into the matching virtual-channel cycle.

Parameters:
- DATA_WIDTH, 64, packet width in bits; fixed at 64 for the ring.
- VC_BIT, 63, packet bit selecting the virtual channel (0 = even, 1 = odd).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  64  processor write data.
- d_out  output  64  processor read data (combinational).
- nicEn  input  1  processor access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
- net_so  output  1  send to router PE input (router pesi).
- net_ro  input  1  router PE input ready (router peri).
- net_do  output  64  packet to router (router pedi).
- polarity  input  1  router polarity: 0 = even cycle, 1 = odd cycle.
- net_si  input  1  send from router PE output (router peso).
- net_ri  output  1  NIC ready to accept (router pero).
- net_di  input  64  packet from router (router pedo).

Behaviour:
- Reset (asynchronous):
  - out_full=0, in_full=0, out_buf=0, in_buf=0.
  - Hence net_so=0, net_ri=1, net_do=0, d_out=0.
- Output channel (processor -> router):
  - Write accept: nicEn=1, nicWrEn=1, addr=10, out_full=0 at the edge. Then out_buf<=d_in, out_full<=1.
  - Write to addr 10 while out_full=1 is dropped; no state change.
  - Writes to addr 00/01/11 are ignored.
  - net_do = out_buf at all times.
  - net_so = out_full & net_ro & (out_buf[VC_BIT] == polarity), combinational.
  - A transfer occurs on the edge where net_so=1. That edge clears out_full; out_buf keeps its value.
  - A packet waits through mismatched-polarity cycles and net_ro=0 cycles indefinitely, with no timeout.
  - Processor write and injection on the same edge: the write is rejected, because acceptance uses out_full before the edge. The new write is accepted no earlier than the following cycle.
  - Minimum latency is 1 cycle from write to net_so, when polarity matches and net_ro=1. Otherwise it is ≤2 cycles after net_ro rises.
- Input channel (router -> processor):
  - net_ri = ~in_full, combinational.
  - Receive: on an edge with net_si=1 and net_ri=1, in_buf<=net_di and in_full<=1.
  - net_si while net_ri=0 is not a transfer; the router must hold the packet.
  - Processor read of addr 00 (nicEn=1, nicWrEn=0): d_out=in_buf in the same cycle, and in_full clears at that edge.
  - net_ri therefore rises the next cycle. Receive and read never coincide, because receive requires in_full=0.
  - Reading addr 00 while in_full=0 returns the stale in_buf and has no side effect.
- Status reads:
  - addr 01: d_out={63'b0,in_full}.
  - addr 11: d_out={63'b0,out_full}.
  - addr 10 read: d_out=out_buf.
  - nicEn=0: d_out=0.
- Reset mid-operation: any pending packet in either buffer is discarded; the outputs return to their reset values immediately.
- The NIC does not modify header fields; hop/direction encoding is the processor's responsibility.

Test Plan:
- Reset asserted mid-transfer with out_full=1 and net_so=1 -> net_so=0, net_ri=1, d_out=0 in the same cycle with no clock edge; status reads give 0.
- Write 64'h8000_0000_0004_00AA (VC=1) with net_ro=1 and polarity toggling from 0 -> net_so=1 only in the polarity=1 cycle. net_do equals the written value. Status at addr 11 then reads 0.
- Write with net_ro=0 for 5 cycles, then a second write of a different value -> second write dropped. After net_ro=1 at the matching polarity, the first value is sent.
- Router drives net_si=1 with net_di=64'h0000_0000_0000_1234 -> net_ri falls next cycle and addr 01 reads 1. Read addr 00 -> d_out=64'h1234, then net_ri=1 the following cycle.
- Router holds net_si=1 with a second packet while the input buffer is full -> no overwrite. The second packet is captured only after the processor read.
- Processor write on the same edge as an injection -> out_full=0 after the edge, the write is ignored, and a retry one cycle later is accepted.
